// File: rtl/dig_tx.sv
// Serialises four packed BCD digits (thousands first) over a valid/ready link,
// optionally skipping leading zeros, with a one-cycle DONE state after the units digit.
module dig_tx #(
    parameter int LZ_SUPPRESS = 1
) (
    input  logic        clk,
    input  logic        rst_tx,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        ready,
    output logic [3:0]  digit,
    output logic [1:0]  pos,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] val_q, val_d;
    logic [1:0]  pos_q, pos_d;
    logic        err_q, err_d;

    function automatic logic bcd_ok(input logic [15:0] v);
        return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
               (v[7:4]   <= 4'd9) && (v[3:0]  <= 4'd9);
    endfunction

    // Highest nonzero digit position; an all-zero value still sends the units digit.
    function automatic logic [1:0] first_pos(input logic [15:0] v);
        if (v[15:12] != 4'd0)     return 2'd3;
        else if (v[11:8] != 4'd0) return 2'd2;
        else if (v[7:4] != 4'd0)  return 2'd1;
        else                      return 2'd0;
    endfunction

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        pos_d   = pos_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    val_d = value;
                    if (bcd_ok(value)) begin
                        state_d = SEND;
                        pos_d   = (LZ_SUPPRESS != 0) ? first_pos(value) : 2'd3;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (ready) begin
                    if (pos_q == 2'd0) state_d = DONE;
                    else               pos_d   = pos_q - 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_tx) begin
            state_q <= IDLE;
            val_q   <= 16'd0;
            pos_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

    assign valid = (state_q == SEND);
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign err   = err_q;
    assign pos   = valid ? pos_q : 2'd0;
    assign digit = valid ? val_q[{pos_q, 2'b00} +: 4] : 4'd0;

endmodule

// File: tb/tb_dig_tx.sv
// Bench for dig_tx: one instance with leading-zero suppression, one without,
// both driven from the same stimulus and checked against a transfer-list model.
module tb_dig_tx;

    logic        clk = 1'b0;
    logic        rst_tx;
    logic        load;
    logic [15:0] value;
    logic        ready;

    logic [3:0] digit1, digit0;
    logic [1:0] pos1, pos0;
    logic       valid1, valid0, busy1, busy0, done1, done0, err1, err0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dig_tx #(.LZ_SUPPRESS(1)) u_lz (
        .clk(clk), .rst_tx(rst_tx), .load(load), .value(value), .ready(ready),
        .digit(digit1), .pos(pos1), .valid(valid1), .busy(busy1), .done(done1), .err(err1)
    );

    dig_tx #(.LZ_SUPPRESS(0)) u_nl (
        .clk(clk), .rst_tx(rst_tx), .load(load), .value(value), .ready(ready),
        .digit(digit0), .pos(pos0), .valid(valid0), .busy(busy0), .done(done0), .err(err0)
    );

    // Packed view: {valid, busy, done, err, pos[1:0], digit[3:0]}
    wire [9:0] o1 = {valid1, busy1, done1, err1, pos1, digit1};
    wire [9:0] o0 = {valid0, busy0, done0, err0, pos0, digit0};

    function automatic logic [9:0] pk(input bit v, input bit b, input bit d, input bit e,
                                      input int p, input int dg);
        logic [1:0] pp;
        logic [3:0] dd;
        pp = 2'(p);
        dd = 4'(dg);
        return {v, b, d, e, pp, dd};
    endfunction

    // Transfer i of a sequence starting at position f with n transfers:
    // i<n sending, i==n done cycle, beyond that idle.
    function automatic logic [9:0] model_out(input logic [15:0] v, input int f, input int i, input int n);
        int p;
        if (i < n) begin
            p = f - i;
            return pk(1, 1, 0, 0, p, int'(v[p*4 +: 4]));
        end else if (i == n) begin
            return pk(0, 1, 1, 0, 0, 0);
        end
        return pk(0, 0, 0, 0, 0, 0);
    endfunction

    function automatic int lead_pos(input logic [15:0] v);
        for (int p = 3; p >= 1; p--)
            if (v[p*4 +: 4] != 4'd0) return p;
        return 0;
    endfunction

    // Entered and left at posedge+1; loads v in the current cycle.
    task automatic run_txn(input logic [15:0] v, input int stall, input int rdy_pct, input string tag);
        int f1, n1, i1, i0, cyc;
        bit fin1, fin0;
        logic [9:0] e1, e0;
        f1 = lead_pos(v);
        n1 = f1 + 1;
        i1 = 0; i0 = 0; cyc = 0; fin1 = 0; fin0 = 0;
        load = 1'b1; value = v; ready = 1'b0;
        @(posedge clk); #1;
        load = 1'b0; value = 16'($urandom);
        while (!(fin1 && fin0) && cyc < 60) begin
            ready = (cyc < stall) ? 1'b0 : ($urandom_range(1, 100) <= rdy_pct);
            if (!fin1 && !fin0 && i1 <= n1 && i0 <= 4) begin
                load  = ($urandom_range(0, 3) == 0);
                value = 16'($urandom);
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            e1 = model_out(v, f1, i1, n1);
            e0 = model_out(v, 3, i0, 4);
            if (!fin1) begin
                n_cmp++;
                if (o1 !== e1) begin
                    n_fail++;
                    $display("FAIL %s lz cyc%0d: got %b want %b (v=%h)", tag, cyc, o1, e1, v);
                end
                if (i1 < n1) begin
                    if (ready) i1++;
                end else if (i1 == n1) i1++;
                else fin1 = 1;
            end
            if (!fin0) begin
                n_cmp++;
                if (o0 !== e0) begin
                    n_fail++;
                    $display("FAIL %s nolz cyc%0d: got %b want %b (v=%h)", tag, cyc, o0, e0, v);
                end
                if (i0 < 4) begin
                    if (ready) i0++;
                end else if (i0 == 4) i0++;
                else fin0 = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        load = 1'b0;
        if (!(fin1 && fin0)) begin
            n_fail++;
            $display("FAIL %s timeout: got unfinished want finished within 60 cycles", tag);
        end
    endtask

    task automatic test_reset();
        rst_tx = 1'b1; load = 1'b1; value = 16'h1234; ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({o1, o0} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b/%b want all zero", o1, o0);
        end
        @(posedge clk); #1;
        rst_tx = 1'b0;
        run_txn(16'h1234, 0, 100, "first_after_reset");
    endtask

    task automatic test_basic();
        run_txn(16'h1234, 0, 100, "v1234");
        run_txn(16'h0042, 0, 100, "v0042");
        run_txn(16'h0000, 0, 100, "v0000");
        run_txn(16'h9009, 0, 100, "v9009");
    endtask

    task automatic test_stall();
        run_txn(16'h5678, 3, 100, "stall5678");
        run_txn(16'h0305, 2, 40, "stall0305");
    endtask

    task automatic test_err();
        logic [15:0] bad [3] = '{16'h12A4, 16'hF000, 16'h000B};
        for (int k = 0; k < 3; k++) begin
            load = 1'b1; value = bad[k]; ready = 1'b1;
            @(posedge clk); #1;
            load = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (o1 !== pk(0, 0, 0, 1, 0, 0) || o0 !== pk(0, 0, 0, 1, 0, 0)) begin
                n_fail++;
                $display("FAIL err_pulse %h: got %b/%b want 0001000000", bad[k], o1, o0);
            end
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++;
            if ({o1, o0} !== 20'd0) begin
                n_fail++;
                $display("FAIL err_clear %h: got %b/%b want all zero", bad[k], o1, o0);
            end
            @(posedge clk); #1;
        end
        run_txn(16'h0801, 0, 100, "after_err");
    endtask

    task automatic test_reset_midsend();
        logic [9:0] exp_t [4];
        exp_t[0] = pk(1, 1, 0, 0, 3, 1);
        exp_t[1] = pk(1, 1, 0, 0, 2, 2);
        exp_t[2] = pk(1, 1, 0, 0, 1, 3);
        exp_t[3] = pk(0, 0, 0, 0, 0, 0);
        load = 1'b1; value = 16'h1234; ready = 1'b1;
        @(posedge clk); #1;
        load = 1'b1; value = 16'h9876;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (o1 !== exp_t[k] || o0 !== exp_t[k]) begin
                n_fail++;
                $display("FAIL midsend_rst step%0d: got %b/%b want %b", k, o1, o0, exp_t[k]);
            end
            @(posedge clk); #1;
            load   = 1'b0;
            rst_tx = (k == 1);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({o1, o0} !== 20'd0) begin
                n_fail++;
                $display("FAIL no_done_after_rst %0d: got %b/%b want all zero", k, o1, o0);
            end
            @(posedge clk); #1;
        end
        run_txn(16'h0009, 0, 100, "v0009");
    endtask

    task automatic test_random();
        logic [15:0] v;
        int k;
        for (int t = 0; t < 25; t++) begin
            v = 16'd0;
            for (int d = 0; d < 4; d++) v[d*4 +: 4] = 4'($urandom_range(0, 9));
            k = $urandom_range(0, 4);
            for (int d = 0; d < k; d++) v[(3-d)*4 +: 4] = 4'd0;
            run_txn(v, $urandom_range(0, 2), 50, "random");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

    task automatic test_back_to_back();
        run_txn(16'h0100, 0, 100, "b2b_a");
        run_txn(16'h9999, 0, 70, "b2b_b");
        run_txn(16'h0010, 1, 100, "b2b_c");
    endtask

    initial begin
        rst_tx = 1'b1; load = 1'b0; value = 16'd0; ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_stall();
        test_err();
        test_reset_midsend();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got still running want finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/dig_tx.md
DIG_TX -- requirements
Module: dig_tx

Interface
REQ-001 The block SHALL have parameter LZ_SUPPRESS, default 1: 1 = skip leading zero digits, 0 = always emit all 4 digits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_tx, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port load, input, 1 bit: request to start sending value; sampled only in IDLE.
REQ-005 The block SHALL have port value, input, 16 bits: 4 packed BCD digits; [15:12] thousands (pos 3) down to [3:0] units (pos 0).
REQ-006 The block SHALL have port ready, input, 1 bit: downstream accepts the current digit.
REQ-007 The block SHALL have port digit, output, 4 bits: current BCD digit.
REQ-008 The block SHALL have port pos, output, 2 bits: decimal position of the current digit, 3 = thousands, 0 = units.
REQ-009 The block SHALL have port valid, output, 1 bit: digit and pos are presented.
REQ-010 The block SHALL have port busy, output, 1 bit: high in SEND and DONE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last digit transfers.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse when a load is rejected.

Function
REQ-013 The FSM SHALL have states IDLE, SEND and DONE; transitions:
- IDLE -> SEND on an accepted load.
- SEND -> DONE on the last transfer.
- DONE -> IDLE unconditionally after 1 cycle.
REQ-014 In IDLE with load=1, value SHALL be captured into an internal 16-bit register.
REQ-015 A load whose value contains any nibble >9 SHALL be rejected:
- err=1 in the next cycle only.
- State stays IDLE; valid and busy stay 0.
REQ-016 The first digit index SHALL be:
- LZ_SUPPRESS=1: the highest position holding a nonzero digit; position 0 if all digits are zero, so at least one digit is always sent.
- LZ_SUPPRESS=0: always 3.
REQ-017 Latency: the first digit SHALL be presented with valid=1 in the cycle after the load cycle.
REQ-018 A transfer SHALL occur in any cycle where valid=1 and ready=1.
REQ-019 While valid=1 and ready=0, digit, pos and valid SHALL hold stable.
REQ-020 After a transfer at pos p>0, the next cycle SHALL present the digit at pos p-1 with valid=1 (no bubble).
REQ-021 After the transfer at pos 0, the next cycle SHALL be the DONE cycle:
- valid=0, done=1, busy=1.
- The following cycle returns to IDLE with busy=0.
REQ-022 load SHALL be ignored in SEND and DONE; the captured value SHALL NOT change until the next IDLE load.
REQ-023 ready SHALL be ignored whenever valid=0.
REQ-024 When valid=0, digit and pos SHALL be driven to 0.
REQ-025 The position counter SHALL be 2 bits, counting down only; it SHALL never wrap from 0 to 3 within one transfer sequence.

Reset
REQ-026 While rst_tx=1 at a rising clk edge, the block SHALL enter IDLE and clear the captured value and position counter.
REQ-027 While rst_tx=1 at a rising clk edge, outputs SHALL be digit=0, pos=0, valid=0, busy=0, done=0, err=0.
REQ-028 Reset SHALL take priority over load and ready in the same cycle.
REQ-029 Reset asserted mid-SEND SHALL abandon the sequence with no done pulse.
REQ-030 After reset deasserts, the block SHALL accept a new load in the first IDLE cycle.

Verification
REQ-031 Load value=0x1234, ready=1, at cycle t -> outputs:
- t+1..t+4: digits 1,2,3,4 with pos 3,2,1,0.
- t+5: valid=0, done=1.
- t+6: busy=0.
REQ-032 Load value=0x0042, ready=1 -> outputs:
- LZ_SUPPRESS=1: digit 4 at pos 1, then digit 2 at pos 0, then done.
- LZ_SUPPRESS=0: digits 0,0,4,2 at pos 3,2,1,0.
REQ-033 Load value=0x0000 with LZ_SUPPRESS=1 -> exactly one transfer (digit 0, pos 0), then done.
REQ-034 Load 0x5678 with ready=0 for 3 cycles, then ready=1 -> digit=5, pos=3, valid=1 held for 4 cycles, then digits 6,7,8 in consecutive cycles.
REQ-035 Load value=0x12A4 -> err=1 for exactly one cycle; valid, busy and done all stay 0; the next valid load is accepted normally.
REQ-036 Reset and re-load sequence:
- Stimulus: assert rst_tx after the second transfer of 0x1234; pulse load=1 during SEND before the reset.
- Required: the mid-SEND load is ignored; all outputs are 0 in the cycle after reset; no done pulse.
- A subsequent load of 0x0009 emits only digit 9 at pos 0.
